// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, Val2 generator, ALU, branch target, NZCV status and EXE/MEM register.
// Latency: 1 cycle from ID/EXE inputs to registered outputs; branch_taken/branch_addr are combinational.
// Backpressure: freeze (SRAM stall) holds the EXE/MEM register and the status register indefinitely.
//
// Ports:
//   clk, rst (async, active-high), freeze
//   ID/EXE inputs: control bits, exe_cmd_in, pc_in, val_rn_in, val_rm_in, shift_operand_in,
//                  signed_imm_in, dest_in, carry_bit_in
//   Forwarding:    sel_src1/sel_src2 select among register value, mem_fwd_val, wb_fwd_val
//   Outputs:       branch_taken/branch_addr (comb), status_out {N,Z,C,V}, EXE/MEM register fields
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             wb_en_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic             imm_in,
    input  logic             branch_in,
    input  logic             s_in,
    input  logic             carry_bit_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val_rn_in,
    input  logic [WIDTH-1:0] val_rm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      signed_imm_in,
    input  logic [3:0]       dest_in,
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [WIDTH-1:0] mem_fwd_val,
    input  logic [WIDTH-1:0] wb_fwd_val,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_addr,
    output logic [3:0]       status_out,
    output logic             wb_en_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic [WIDTH-1:0] alu_res_out,
    output logic [WIDTH-1:0] st_val_out,
    output logic [3:0]       dest_out
);

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] x, input logic [4:0] n);
        if (n == 5'd0) return x;
        return (x >> n) | (x << (WIDTH - int'(n)));
    endfunction

    logic [WIDTH-1:0] op1, fwd_rm, val2, res;
    logic [WIDTH:0]   sum;
    logic             c_new, v_new, cmd_ok, is_add, is_sub;
    logic [3:0]       flags;

    // Forwarding: code 11 falls back to the register value
    always_comb begin
        case (sel_src1)
            2'b01:   op1 = mem_fwd_val;
            2'b10:   op1 = wb_fwd_val;
            default: op1 = val_rn_in;
        endcase
        case (sel_src2)
            2'b01:   fwd_rm = mem_fwd_val;
            2'b10:   fwd_rm = wb_fwd_val;
            default: fwd_rm = val_rm_in;
        endcase
    end

    // Val2: memory offset beats immediate beats shifted register
    always_comb begin
        if (mem_read_in || mem_write_in) begin
            val2 = {{(WIDTH-12){1'b0}}, shift_operand_in};
        end else if (imm_in) begin
            val2 = ror({{(WIDTH-8){1'b0}}, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
        end else begin
            case (shift_operand_in[6:5])
                2'b00:   val2 = fwd_rm << shift_operand_in[11:7];
                2'b01:   val2 = fwd_rm >> shift_operand_in[11:7];
                2'b10:   val2 = $signed(fwd_rm) >>> shift_operand_in[11:7];
                default: val2 = ror(fwd_rm, shift_operand_in[11:7]);
            endcase
        end
    end

    // ALU; subtraction is op1 + ~val2 + carry-in so the carry-out is already NOT borrow
    always_comb begin
        sum    = '0;
        res    = '0;
        cmd_ok = 1'b1;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (exe_cmd_in)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010: begin is_add = 1'b1; sum = {1'b0, op1} + {1'b0, val2}; end
            4'b0011: begin is_add = 1'b1; sum = {1'b0, op1} + {1'b0, val2} + {{WIDTH{1'b0}}, carry_bit_in}; end
            4'b0100: begin is_sub = 1'b1; sum = {1'b0, op1} + {1'b0, ~val2} + {{WIDTH{1'b0}}, 1'b1}; end
            4'b0101: begin is_sub = 1'b1; sum = {1'b0, op1} + {1'b0, ~val2} + {{WIDTH{1'b0}}, carry_bit_in}; end
            4'b0110: res = op1 & val2;
            4'b0111: res = op1 | val2;
            4'b1000: res = op1 ^ val2;
            default: cmd_ok = 1'b0;
        endcase
        if (is_add || is_sub) res = sum[WIDTH-1:0];
    end

    // Logic and move ops keep C and V from the current status
    always_comb begin
        c_new = status_out[1];
        v_new = status_out[0];
        if (is_add) begin
            c_new = sum[WIDTH];
            v_new = (op1[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
        end else if (is_sub) begin
            c_new = sum[WIDTH];
            v_new = (op1[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != op1[WIDTH-1]);
        end
        flags = {res[WIDTH-1], (res == '0), c_new, v_new};
    end

    assign branch_taken = branch_in;
    assign branch_addr  = pc_in + {{(WIDTH-26){signed_imm_in[23]}}, signed_imm_in, 2'b00};

    // Registered state
    logic             wb_en_q, mem_read_q, mem_write_q;
    logic             wb_en_d, mem_read_d, mem_write_d;
    logic [WIDTH-1:0] alu_res_q, st_val_q, alu_res_d, st_val_d;
    logic [3:0]       dest_q, dest_d, status_q, status_d;

    always_comb begin
        wb_en_d     = freeze ? wb_en_q     : wb_en_in;
        mem_read_d  = freeze ? mem_read_q  : mem_read_in;
        mem_write_d = freeze ? mem_write_q : mem_write_in;
        alu_res_d   = freeze ? alu_res_q   : res;
        st_val_d    = freeze ? st_val_q    : fwd_rm;
        dest_d      = freeze ? dest_q      : dest_in;
        status_d    = (!freeze && s_in && cmd_ok) ? flags : status_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            alu_res_q   <= '0;
            st_val_q    <= '0;
            dest_q      <= '0;
            status_q    <= '0;
        end else begin
            wb_en_q     <= wb_en_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            alu_res_q   <= alu_res_d;
            st_val_q    <= st_val_d;
            dest_q      <= dest_d;
            status_q    <= status_d;
        end
    end

    assign wb_en_out     = wb_en_q;
    assign mem_read_out  = mem_read_q;
    assign mem_write_out = mem_write_q;
    assign alu_res_out   = alu_res_q;
    assign st_val_out    = st_val_q;
    assign dest_out      = dest_q;
    assign status_out    = status_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed scenarios plus randomized traffic against a behavioural model.
// Inputs change 1ns after posedge; registered outputs are sampled 1ns after posedge.
// Freeze and mid-stall reset are exercised both directed and at random.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic        wb_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in, carry_bit_in;
    logic [3:0]  exe_cmd_in, dest_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in, mem_fwd_val, wb_fwd_val;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_in;
    logic [1:0]  sel_src1, sel_src2;
    logic        branch_taken, wb_en_out, mem_read_out, mem_write_out;
    logic [31:0] branch_addr, alu_res_out, st_val_out;
    logic [3:0]  status_out, dest_out;

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .imm_in(imm_in), .branch_in(branch_in), .s_in(s_in), .carry_bit_in(carry_bit_in),
        .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_in(signed_imm_in), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .status_out(status_out),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .alu_res_out(alu_res_out), .st_val_out(st_val_out), .dest_out(dest_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state of everything the DUT registers
    logic [3:0]  m_status, m_dest;
    logic        m_wb, m_mr, m_mw;
    logic [31:0] m_res, m_st;

    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        logic [31:0] r = x;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] m_asr(input logic [31:0] x, input int n);
        logic [31:0] r = x;
        for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] reg_val);
        if (sel == 2'd1) return mem_fwd_val;
        if (sel == 2'd2) return wb_fwd_val;
        return reg_val;
    endfunction

    function automatic logic [31:0] m_val2();
        logic [31:0] rm = m_fwd(sel_src2, val_rm_in);
        logic [31:0] low8;
        int amt = int'(shift_operand_in[11:7]);
        if (mem_read_in || mem_write_in) return {20'd0, shift_operand_in};
        if (imm_in) begin
            low8 = {24'd0, shift_operand_in[7:0]};
            return m_ror(low8, 2 * int'(shift_operand_in[11:8]));
        end
        case (shift_operand_in[6:5])
            2'd0:    return rm << amt;
            2'd1:    return rm >> amt;
            2'd2:    return m_asr(rm, amt);
            default: return m_ror(rm, amt);
        endcase
    endfunction

    function automatic logic [31:0] m_branch();
        longint t = longint'(pc_in) + longint'($signed(signed_imm_in)) * 4;
        return t[31:0];
    endfunction

    // Arithmetic done in 64-bit integers: carry and overflow come from range checks
    task automatic m_exec(output logic [31:0] res, output logic [3:0] fl, output bit ok);
        logic [31:0] a = m_fwd(sel_src1, val_rn_in);
        logic [31:0] b = m_val2();
        longint ua = longint'(a), ub = longint'(b);
        longint sa = longint'($signed(a)), sb = longint'($signed(b));
        longint us, ss, k;
        bit c = m_status[1], v = m_status[0];
        ok = 1;
        res = 32'd0;
        case (exe_cmd_in)
            4'd1: res = b;
            4'd9: res = ~b;
            4'd2, 4'd3: begin
                k = (exe_cmd_in == 4'd3) ? longint'(carry_bit_in) : 0;
                us = ua + ub + k; ss = sa + sb + k;
                res = us[31:0];
                c = us >= 64'sh1_0000_0000;
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                k = (exe_cmd_in == 4'd5) ? longint'(!carry_bit_in) : 0;
                us = ua - ub - k; ss = sa - sb - k;
                res = us[31:0];
                c = us >= 0;
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd6: res = a & b;
            4'd7: res = a | b;
            4'd8: res = a ^ b;
            default: ok = 0;
        endcase
        fl = {res[31], res == 32'd0, c, v};
    endtask

    task automatic m_clear();
        m_status = 4'd0; m_dest = 4'd0; m_wb = 0; m_mr = 0; m_mw = 0; m_res = 32'd0; m_st = 32'd0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".status"}, {28'd0, status_out}, {28'd0, m_status});
        chk({tag, ".res"}, alu_res_out, m_res);
        chk({tag, ".st"}, st_val_out, m_st);
        chk({tag, ".ctl"}, {25'd0, wb_en_out, mem_read_out, mem_write_out, dest_out},
            {25'd0, m_wb, m_mr, m_mw, m_dest});
    endtask

    task automatic nop();
        freeze = 0; wb_en_in = 0; mem_read_in = 0; mem_write_in = 0; imm_in = 0; branch_in = 0;
        s_in = 0; carry_bit_in = 0; exe_cmd_in = 4'd0; dest_in = 4'd0; pc_in = 32'd0;
        val_rn_in = 32'd0; val_rm_in = 32'd0; mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
        shift_operand_in = 12'd0; signed_imm_in = 24'd0; sel_src1 = 2'd0; sel_src2 = 2'd0;
    endtask

    task automatic randomize_inputs();
        freeze = ($urandom_range(0, 3) == 0);
        wb_en_in = 1'($urandom); imm_in = 1'($urandom); branch_in = 1'($urandom);
        s_in = 1'($urandom); carry_bit_in = 1'($urandom);
        mem_read_in = ($urandom_range(0, 6) == 0);
        mem_write_in = ($urandom_range(0, 6) == 0);
        exe_cmd_in = 4'($urandom); dest_in = 4'($urandom);
        pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        mem_fwd_val = $urandom; wb_fwd_val = $urandom;
        shift_operand_in = 12'($urandom); signed_imm_in = 24'($urandom);
        sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
        // Bias toward edge operands so carries, zero and overflow occur
        if ($urandom_range(0, 4) == 0) val_rn_in = 32'h7FFF_FFFF;
        if ($urandom_range(0, 4) == 0) val_rm_in = 32'h8000_0000;
        if ($urandom_range(0, 5) == 0) val_rm_in = val_rn_in;
    endtask

    // Inputs are already driven; check comb outputs, predict, clock, check registers
    task automatic step(input string tag);
        logic [31:0] r;
        logic [3:0]  f;
        bit          ok;
        #1;
        chk({tag, ".btaken"}, {31'd0, branch_taken}, {31'd0, branch_in});
        chk({tag, ".baddr"}, branch_addr, m_branch());
        m_exec(r, f, ok);
        if (!freeze) begin
            m_wb = wb_en_in; m_mr = mem_read_in; m_mw = mem_write_in;
            m_res = r; m_st = m_fwd(sel_src2, val_rm_in); m_dest = dest_in;
            if (s_in && ok) m_status = f;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        nop();
        rst = 1;
        m_clear();
        #2;
        check_regs("reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // ADD 5 + imm 3
        nop(); exe_cmd_in = 4'd2; val_rn_in = 32'd5; imm_in = 1; shift_operand_in = 12'h003; s_in = 1;
        step("t1_add");
        chk("t1_res8", alu_res_out, 32'd8);
        chk("t1_nzcv", {28'd0, status_out}, 32'd0);

        // SUB 7 - 7 sets Z and C
        nop(); exe_cmd_in = 4'd4; val_rn_in = 32'd7; imm_in = 1; shift_operand_in = 12'h007; s_in = 1;
        step("t2_sub");
        chk("t2_nzcv", {28'd0, status_out}, 32'h6);
        nop(); exe_cmd_in = 4'd4; val_rn_in = 32'd9; imm_in = 1; shift_operand_in = 12'h007;
        step("t2_nos");
        chk("t2_hold", {28'd0, status_out}, 32'h6);

        // Rotated immediate and ASR
        nop(); exe_cmd_in = 4'd1; imm_in = 1; shift_operand_in = 12'h4FF;
        step("t3_rot");
        chk("t3_rotval", alu_res_out, 32'hFF00_0000);
        nop(); exe_cmd_in = 4'd1; val_rm_in = 32'h8000_0000; shift_operand_in = {5'd4, 2'b10, 5'd0};
        step("t3_asr");
        chk("t3_asrval", alu_res_out, 32'hF800_0000);

        // Forwarded STR
        nop(); exe_cmd_in = 4'd2; mem_write_in = 1; sel_src1 = 2'd1; mem_fwd_val = 32'h10;
        sel_src2 = 2'd2; wb_fwd_val = 32'hAB; shift_operand_in = 12'd4; val_rn_in = 32'h55;
        step("t4_str");
        chk("t4_addr", alu_res_out, 32'h14);
        chk("t4_stval", st_val_out, 32'hAB);

        // Branch target
        nop(); pc_in = 32'h100; signed_imm_in = 24'hFFFFFE; branch_in = 1;
        #1;
        chk("t5_btaken", {31'd0, branch_taken}, 32'd1);
        chk("t5_baddr", branch_addr, 32'hF8);
        step("t5");

        // Freeze for three cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            freeze = 1;
            step("t6_frz");
        end
        nop(); exe_cmd_in = 4'd2; val_rn_in = 32'h7FFF_FFFF; imm_in = 1; shift_operand_in = 12'h001; s_in = 1;
        step("t6_ovf");
        chk("t6_nzcv", {28'd0, status_out}, 32'h9);

        // Reset during a stall clears everything, capture resumes afterwards
        randomize_inputs(); freeze = 1;
        rst = 1; m_clear();
        #1;
        check_regs("t7_rst");
        rst = 0;
        randomize_inputs(); freeze = 0;
        step("t7_resume");

        for (int n = 0; n < 400; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 49) == 0) begin
                rst = 1; m_clear();
                #1;
                check_regs("rnd_rst");
                rst = 0;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
